axi_demux_w_sched: RTL and testbench

AXI_DEMUX_W_SCHED -- requirements
Module: axi_demux_w_sched

---
 rtl/axi_demux_w_sched.sv | 113 +++++++++++
 tb/tb_axi_demux_w_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_demux_w_sched.sv
// rtl/axi_demux_w_sched.sv - W-channel scheduler for an AXI demux: queues AW select decisions, routes W bursts in order.
// Select values at or above NoMstPorts route to an internal sink that accepts and drops the burst.
module axi_demux_w_sched #(
    parameter int unsigned NoMstPorts  = 32'd4,
    parameter int unsigned MaxTrans    = 32'd8,
    parameter int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             aw_valid_i,
    input  logic [SelectWidth-1:0]           aw_select_i,
    output logic                             aw_ready_o,
    input  logic                             w_valid_i,
    input  logic                             w_last_i,
    output logic                             w_ready_o,
    output logic [NoMstPorts-1:0]            mst_w_valid_o,
    input  logic [NoMstPorts-1:0]            mst_w_ready_i,
    output logic [SelectWidth-1:0]           w_sel_o,
    output logic                             decode_err_o,
    output logic [$clog2(MaxTrans+1)-1:0]    pending_o
);

    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        SINK
    } state_e;

    state_e                 state;
    logic [SelectWidth-1:0] fifo_q [MaxTrans];
    logic [PtrWidth-1:0]    wr_ptr_q;
    logic [PtrWidth-1:0]    rd_ptr_q;
    logic [CntWidth-1:0]    count_q;
    logic                   decode_err_q;
    logic [SelectWidth-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxTrans - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full       = (count_q == CntWidth'(MaxTrans));
    assign empty      = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign aw_ready_o = !full;
    assign push       = aw_valid_i && !full;
    assign pop        = (state != IDLE) && w_valid_i && w_ready_o && w_last_i;

    // State is a pure decode of the queue head; nothing extra is registered.
    always_comb begin
        state = IDLE;
        if (!empty) begin
            state = (32'(head) >= NoMstPorts) ? SINK : ROUTE;
        end
    end

    always_comb begin
        mst_w_valid_o = '0;
        w_ready_o     = 1'b0;
        w_sel_o       = '0;
        case (state)
            ROUTE: begin
                w_sel_o = head;
                for (int unsigned i = 0; i < NoMstPorts; i++) begin
                    if (head == SelectWidth'(i)) begin
                        mst_w_valid_o[i] = w_valid_i;
                        w_ready_o        = mst_w_ready_i[i];
                    end
                end
            end
            SINK:    w_ready_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            decode_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: ;
            endcase
            decode_err_q <= pop && (state == SINK);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= aw_select_i;
        end
    end

    assign decode_err_o = decode_err_q;
    assign pending_o    = count_q;

endmodule

// File: tb/tb_axi_demux_w_sched.sv
// tb/tb_axi_demux_w_sched.sv - Directed-vector and model-based bench for axi_demux_w_sched.
module tb_axi_demux_w_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       aw_valid, w_valid, w_last;
    logic [1:0] aw_select;
    logic [3:0] mst_ready;
    logic       aw_ready, w_ready, decode_err;
    logic [3:0] mst_valid, pending;
    logic [1:0] w_sel;

    logic       aw_valid_b, w_valid_b, w_last_b;
    logic [1:0] aw_select_b;
    logic [2:0] mst_ready_b;
    logic       aw_ready_b, w_ready_b, decode_err_b;
    logic [2:0] mst_valid_b;
    logic [3:0] pending_b;
    logic [1:0] w_sel_b;

    axi_demux_w_sched dut4 (
        .clk_i(clk), .rst_ni(rst_n), .aw_valid_i(aw_valid), .aw_select_i(aw_select),
        .aw_ready_o(aw_ready), .w_valid_i(w_valid), .w_last_i(w_last), .w_ready_o(w_ready),
        .mst_w_valid_o(mst_valid), .mst_w_ready_i(mst_ready), .w_sel_o(w_sel),
        .decode_err_o(decode_err), .pending_o(pending)
    );

    axi_demux_w_sched #(.NoMstPorts(3), .MaxTrans(8)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .aw_valid_i(aw_valid_b), .aw_select_i(aw_select_b),
        .aw_ready_o(aw_ready_b), .w_valid_i(w_valid_b), .w_last_i(w_last_b), .w_ready_o(w_ready_b),
        .mst_w_valid_o(mst_valid_b), .mst_w_ready_i(mst_ready_b), .w_sel_o(w_sel_b),
        .decode_err_o(decode_err_b), .pending_o(pending_b)
    );

    typedef struct {
        logic       aw_v;
        logic [1:0] aw_s;
        logic       w_v;
        logic       w_l;
        logic [3:0] mrdy;
        logic       e_awr;
        logic       e_wr;
        logic [3:0] e_mv;
        logic [1:0] e_sel;
        logic [3:0] e_pend;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] model[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    function automatic vec_t mkv(logic aw_v, logic [1:0] aw_s, logic w_v, logic w_l, logic [3:0] mrdy,
                                 logic e_awr, logic e_wr, logic [3:0] e_mv, logic [1:0] e_sel, logic [3:0] e_pend);
        vec_t v;
        v.aw_v = aw_v; v.aw_s = aw_s; v.w_v = w_v; v.w_l = w_l; v.mrdy = mrdy;
        v.e_awr = e_awr; v.e_wr = e_wr; v.e_mv = e_mv; v.e_sel = e_sel; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] as, input logic wv, input logic wl, input logic [3:0] mr);
        aw_valid = av; aw_select = as; w_valid = wv; w_last = wl; mst_ready = mr;
    endtask

    initial begin
        logic [1:0] sel;
        logic [3:0] exp_mv;
        logic       exp_awr, exp_wr, do_pop;
        logic [1:0] exp_sel;
        int         pulses;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'hF);
        aw_valid_b = 0; aw_select_b = 0; w_valid_b = 0; w_last_b = 0; mst_ready_b = 3'b111;
        #12;
        chk("reset aw_ready", aw_ready, 1);
        chk("reset w_ready", w_ready, 0);
        chk("reset mst_valid", mst_valid, 0);
        chk("reset pending", pending, 0);
        chk("reset w_sel", w_sel, 0);
        chk("reset decode_err", decode_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3-beat burst to port 2, then queued 0,1,0 with port 0 stalled for 5 cycles
        vecs.push_back(mkv(0, 0, 0, 0, 4'hF, 1, 0, 4'b0000, 0, 0));
        vecs.push_back(mkv(1, 2, 1, 0, 4'hF, 1, 0, 4'b0000, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 4'hF, 1, 1, 4'b0100, 2, 1));
        vecs.push_back(mkv(0, 0, 1, 0, 4'hF, 1, 1, 4'b0100, 2, 1));
        vecs.push_back(mkv(0, 0, 1, 1, 4'hF, 1, 1, 4'b0100, 2, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 4'hF, 1, 0, 4'b0000, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 1, 4'hF, 1, 0, 4'b0000, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 4'hE, 1, 0, 4'b0000, 0, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 4'hE, 1, 0, 4'b0000, 0, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 4'hE, 1, 0, 4'b0000, 0, 2));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(0, 0, 1, 1, 4'hE, 1, 0, 4'b0001, 0, 3));
        vecs.push_back(mkv(0, 0, 1, 1, 4'hF, 1, 1, 4'b0001, 0, 3));
        vecs.push_back(mkv(0, 0, 1, 1, 4'hF, 1, 1, 4'b0010, 1, 2));
        vecs.push_back(mkv(0, 0, 1, 1, 4'hF, 1, 1, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 4'hF, 1, 0, 4'b0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].aw_v, vecs[i].aw_s, vecs[i].w_v, vecs[i].w_l, vecs[i].mrdy);
            #1;
            chk($sformatf("vec%0d aw_ready", i), aw_ready, vecs[i].e_awr);
            chk($sformatf("vec%0d w_ready", i), w_ready, vecs[i].e_wr);
            chk($sformatf("vec%0d mst_valid", i), mst_valid, vecs[i].e_mv);
            chk($sformatf("vec%0d w_sel", i), w_sel, vecs[i].e_sel);
            chk($sformatf("vec%0d pending", i), pending, vecs[i].e_pend);
            chk($sformatf("vec%0d decode_err", i), decode_err, 0);
        end

        // Fill to full, refuse a push while full and during the freeing pop, then wrap the pointers
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1, 2'(k % 4), 0, 0, 4'hF);
            #1;
            chk($sformatf("fill%0d aw_ready", k), aw_ready, 1);
            model.push_back(2'(k % 4));
        end
        @(negedge clk);
        drive(1, 3, 0, 0, 4'hF);
        #1;
        chk("full aw_ready", aw_ready, 0);
        chk("full pending", pending, 8);
        @(negedge clk);
        drive(1, 3, 1, 1, 4'hF);
        #1;
        chk("full pop aw_ready", aw_ready, 0);
        chk("full pop w_sel", w_sel, model[0]);
        void'(model.pop_front());
        @(negedge clk);
        drive(0, 0, 0, 0, 4'hF);
        #1;
        chk("after pop aw_ready", aw_ready, 1);
        chk("after pop pending", pending, 7);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            sel = 2'((k * 3 + 1) % 4);
            drive(1, sel, 1, 1, 4'hF);
            #1;
            chk($sformatf("wrap%0d w_sel", k), w_sel, model[0]);
            chk($sformatf("wrap%0d mst_valid", k), mst_valid, 4'(1) << model[0]);
            chk($sformatf("wrap%0d pending", k), pending, model.size());
            model.push_back(sel);
            void'(model.pop_front());
        end
        while (model.size() > 0) begin
            @(negedge clk);
            drive(0, 0, 1, 1, 4'hF);
            #1;
            chk("drain w_sel", w_sel, model[0]);
            chk("drain pending", pending, model.size());
            void'(model.pop_front());
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 4'hF);
        #1;
        chk("drained pending", pending, 0);

        // Asynchronous reset during beat 2 of a 4-beat burst
        @(negedge clk);
        drive(1, 1, 0, 0, 4'hF);
        @(negedge clk);
        drive(0, 0, 1, 0, 4'hF);
        #1;
        chk("rst beat1 mst_valid", mst_valid, 4'b0010);
        @(negedge clk);
        #1;
        chk("rst beat2 mst_valid", mst_valid, 4'b0010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst aw_ready", aw_ready, 1);
        chk("midrst w_ready", w_ready, 0);
        chk("midrst mst_valid", mst_valid, 0);
        chk("midrst pending", pending, 0);
        chk("midrst w_sel", w_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst beat3 mst_valid", mst_valid, 0);
        chk("post rst beat3 w_ready", w_ready, 0);
        @(negedge clk);
        drive(0, 0, 1, 1, 4'hF);
        #1;
        chk("post rst beat4 mst_valid", mst_valid, 0);
        @(negedge clk);
        drive(1, 3, 1, 1, 4'hF);
        #1;
        chk("new aw no bypass", mst_valid, 0);
        @(negedge clk);
        drive(0, 0, 1, 1, 4'hF);
        #1;
        chk("new aw routed", mst_valid, 4'b1000);
        chk("new aw w_sel", w_sel, 3);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'hF);
        #1;
        chk("new aw closed", pending, 0);

        // Out-of-range select on the 3-port instance
        pulses = 0;
        @(negedge clk);
        aw_valid_b = 1; aw_select_b = 3;
        @(negedge clk);
        aw_valid_b = 0; w_valid_b = 1; w_last_b = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 2) begin
                chk($sformatf("sink%0d w_ready", c), w_ready_b, 1);
                chk($sformatf("sink%0d mst_valid", c), mst_valid_b, 0);
                chk($sformatf("sink%0d w_sel", c), w_sel_b, 0);
            end
            chk($sformatf("sink%0d decode_err", c), decode_err_b, (c == 2) ? 1 : 0);
            if (decode_err_b) pulses++;
            @(negedge clk);
            w_last_b = (c == 0);
            w_valid_b = (c == 0);
        end
        chk("sink pulse count", pulses, 1);
        aw_valid_b = 1; aw_select_b = 1;
        @(negedge clk);
        aw_valid_b = 0; w_valid_b = 1; w_last_b = 1;
        #1;
        chk("after sink mst_valid", mst_valid_b, 3'b010);
        chk("after sink w_sel", w_sel_b, 1);
        chk("after sink w_ready", w_ready_b, 1);
        @(negedge clk);
        w_valid_b = 0; w_last_b = 0;

        // Random traffic against a queue model
        model.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            drive(logic'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
            #1;
            exp_awr = (model.size() < 8);
            exp_mv  = 0;
            exp_wr  = 0;
            exp_sel = 0;
            if (model.size() > 0) begin
                exp_sel = model[0];
                exp_mv  = w_valid ? (4'(1) << model[0]) : 4'b0000;
                exp_wr  = mst_ready[model[0]];
            end
            chk($sformatf("rand%0d {awr,wr,mv,sel,pend,err}", c),
                {aw_ready, w_ready, mst_valid, w_sel, pending, decode_err},
                {exp_awr, exp_wr, exp_mv, exp_sel, 4'(model.size()), 1'b0});
            do_pop = (model.size() > 0) && w_valid && exp_wr && w_last;
            if (do_pop) void'(model.pop_front());
            if (aw_valid && exp_awr) model.push_back(aw_select);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
